fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write arbiter that lets NREQ independent valid/ready sources share one `genericFifo` write port. Grants are burst-granular: a source holds the FIFO until its `last` beat or until MAXBURST beats have been written, so bursts from different sources are never interleaved in the FIFO. The block sits between the sources and the FIFO `din`/`we`/`full` ports. The FIFO read side is untouched.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `dw`, 8: data width; must match the FIFO `dw`.
- `MAXBURST`, 8: maximum beats per grant (1..256).
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  NREQ  per-source beat valid.
- `req_data`  in  NREQ*dw  source i occupies bits [i*dw +: dw].
- `req_last`  in  NREQ  per-source end-of-burst flag, qualified by valid.
- `req_ready`  out  NREQ  per-source beat accepted this cycle.
- `fifo_din`  out  dw  to FIFO `din`.
- `fifo_we`  out  1  to FIFO `we`.
- `fifo_full`  in  1  from FIFO `full`.
- `grant`  out  NREQ  one-hot current owner; 0 when idle.
- `busy`  out  1  high in BURST.
- `trunc_count`  out  16  saturating count of grants ended by MAXBURST.

## Operation
- States:
  - IDLE: no owner.
  - BURST: `grant` is one-hot.
- IDLE → BURST:
  - Triggered when any `req_valid` is high.
  - The winner is the first asserted valid at or after `rr_ptr`, searching upward modulo NREQ.
  - On the transition, `grant` is registered and the beat counter is cleared.
- In BURST, for owner i:
  - `req_ready[i] = !fifo_full`.
  - `fifo_we = req_valid[i] & !fifo_full`.
  - `fifo_din = req_data[i]`.
  - All other `req_ready` bits are 0.
- A beat is accepted when `fifo_we` is high. Each accepted beat increments the beat counter (width clog2(MAXBURST)+1).
- BURST → IDLE happens on the cycle an accepted beat either has `req_last[i]=1` or is beat number MAXBURST.
  - On that transition, `rr_ptr` ← (i+1) mod NREQ and `grant` ← 0.
  - If the exit was caused by MAXBURST and `req_last` was 0, `trunc_count` increments. It saturates at 16'hFFFF.
- A truncated source keeps its place in the data stream. Its next grant continues the same burst; the block does not alter data.
- Owner deasserting `req_valid` mid-burst: the grant is held with no writes. There is no timeout.
- `fifo_full` mid-burst: writes stall and the grant is held. The beat counter does not advance.
- `req_valid` on non-owners is ignored; those sources see `req_ready=0`.
- Reset (async, any state):
  - Registers: state=IDLE, `grant`=0, `rr_ptr`=0, beat counter=0, `trunc_count`=0.
  - Outputs: `fifo_we`=0 and all `req_ready`=0 immediately, combinationally from state.
  - A burst interrupted by reset is not resumed.

## Timing
- Arbitration latency: `req_valid` rising in IDLE at cycle n gives `grant` and `busy` at cycle n+1. The first possible write is also cycle n+1.
- Terminating beat at cycle m: IDLE at m+1, the next grant at m+2 at the earliest. There is exactly one bubble cycle between grants.
- `fifo_we`, `fifo_din` and `req_ready` are combinational from registered `grant` and the current inputs, with no added latency. `fifo_full` is sampled the same cycle.
- Peak throughput is one beat per cycle within a burst. Worst-case wait for a continuously requesting source is (NREQ−1)·(MAXBURST+1) cycles, provided no stalls occur.

## Structure
- Shared package holds:
  - the state encoding (IDLE=1'b0, BURST=1'b1);
  - a clog2 function for the beat counter and `rr_ptr` widths.
- Sub-module `rr_priority_pick`: combinational. Inputs are `req` [NREQ] and `ptr`; output is a one-hot winner. It rotates the request vector by `ptr`, takes the lowest set bit, then rotates back.
- `trunc_count` saturation logic stays inline.

## Test plan
- **Single source:** NREQ=4, MAXBURST=8, FIFO aw=3.
  - Stimulus: source 2 sends a 3-beat burst 0xA1,0xA2,0xA3 with `last` on 0xA3.
  - Required: `grant`=4'b0100 one cycle after valid; three consecutive `fifo_we`; IDLE next; `rr_ptr`=3.
- **Fairness:** all four sources continuously valid, 2-beat bursts.
  - Required: grant order 0,1,2,3,0.
  - Required: FIFO contents show no interleaving within a burst.
  - Required: exactly one bubble cycle between bursts.
- **Truncation:** source 0 sends a 10-beat burst with `last` on beat 10.
  - Required: grant released after beat 8; `trunc_count`=1.
  - Required: source 1 (valid) served next, then source 0 writes its remaining 2 beats; `trunc_count` stays 1.
- **Full stall:** `fifo_full` forced high for 5 cycles mid-burst.
  - Required: `req_ready`=0 and `fifo_we`=0 during the stall; grant held; beat count unchanged; burst completes after release with no lost or duplicated beats.
- **Reset:** `rst_n` pulsed low asynchronously between clock edges, mid-burst at beat 3.
  - Required: `grant`, `busy`, `fifo_we` and `req_ready` all 0 before the next edge; `trunc_count`=0.
  - Required: after release, the first grant goes to the lowest valid index.
- **Saturation:** preload via repeated truncations (or force) to 16'hFFFE, then cause 3 more truncations.
  - Required: `trunc_count` reads 16'hFFFF and holds.

Source files
------------

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state encoding and the
// width helper used to size the round-robin pointer and the beat counter.
package fifo_write_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Ceiling log2; returns 0 for an argument of 1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Source-side and FIFO-side write bus shared by the arbiter and its environment.
// The master modport is the environment: the sources plus the FIFO full flag.
interface fifo_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int dw   = 8
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*dw-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic [dw-1:0]      fifo_din;
    logic               fifo_we;
    logic               fifo_full;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output fifo_full,
        input  req_ready,
        input  fifo_din,
        input  fifo_we
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  fifo_full,
        output req_ready,
        output fifo_din,
        output fifo_we
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: rotate the requests so ptr sits at bit 0,
// keep the lowest set bit, and rotate the one-hot result back into place.
module rr_priority_pick
    import fifo_write_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  winner
);

    logic [NREQ-1:0]  rotated;
    logic [NREQ-1:0]  lowest;
    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        rotated = '0;
        lowest  = '0;
        winner  = '0;
        found   = 1'b0;
        idx     = '0;
        for (int j = 0; j < NREQ; j++) begin
            idx        = PTR_W'((j + int'(ptr)) % NREQ);
            rotated[j] = req[idx];
        end
        for (int j = 0; j < NREQ; j++) begin
            if (rotated[j] && !found) begin
                lowest[j] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            idx         = PTR_W'((j + int'(ptr)) % NREQ);
            winner[idx] = lowest[j];
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Burst-granular round-robin arbiter sharing one FIFO write port among NREQ
// valid/ready sources; a grant lasts until the owner's last beat or MAXBURST beats.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int dw       = 8,
    parameter int MAXBURST = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_write_arbiter_if.slave  bus,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [15:0]          trunc_count
);

    localparam int PTR_W = clog2(NREQ);
    localparam int CNT_W = clog2(MAXBURST) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAXBURST - 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NREQ - 1);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [NREQ-1:0]  grant_q;
    logic [NREQ-1:0]  winner;
    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] owner_idx;
    logic [PTR_W-1:0] next_ptr;
    logic [CNT_W-1:0] beat_cnt_q;
    logic [15:0]      trunc_q;
    logic             owner_last;
    logic             at_max;
    logic             burst_end;
    logic             truncate;

    rr_priority_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (bus.req_valid),
        .ptr    (rr_ptr_q),
        .winner (winner)
    );

    // Owner mux: everything the FIFO and sources see is gated by the registered state,
    // so an asynchronous reset silences writes and ready immediately.
    always_comb begin
        bus.req_ready = '0;
        bus.fifo_we   = 1'b0;
        bus.fifo_din  = '0;
        owner_last    = 1'b0;
        owner_idx     = '0;
        if (state_q == BURST) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_q[i]) begin
                    owner_idx        = PTR_W'(i);
                    bus.req_ready[i] = !bus.fifo_full;
                    bus.fifo_we      = bus.req_valid[i] & !bus.fifo_full;
                    bus.fifo_din     = bus.req_data[i*dw +: dw];
                    owner_last       = bus.req_last[i];
                end
            end
        end
    end

    assign at_max    = (beat_cnt_q == LAST_BEAT);
    assign burst_end = bus.fifo_we & (owner_last | at_max);
    assign truncate  = bus.fifo_we & at_max & !owner_last;
    assign next_ptr  = (owner_idx == LAST_IDX) ? '0 : owner_idx + PTR_W'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|bus.req_valid) state_d = BURST;
            BURST:   if (burst_end)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant, pointer and counters; a stalled or empty cycle leaves the beat count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            trunc_q    <= '0;
        end else if (state_q == IDLE) begin
            if (|bus.req_valid) begin
                grant_q    <= winner;
                beat_cnt_q <= '0;
            end
        end else if (burst_end) begin
            grant_q    <= '0;
            rr_ptr_q   <= next_ptr;
            beat_cnt_q <= '0;
            if (truncate && (trunc_q != 16'hFFFF)) begin
                trunc_q <= trunc_q + 16'd1;
            end
        end else if (bus.fifo_we) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q == BURST);
    assign trunc_count = trunc_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (NREQ=4, dw=8, MAXBURST=8): a vector table
// for single-source and fairness traffic, then hand sequences for the multi-cycle cases.
module tb_fifo_write_arbiter;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        full;
        logic [3:0]  exp_grant;
        logic [3:0]  exp_ready;
        logic        exp_we;
        logic [7:0]  exp_din;
        logic        exp_busy;
        logic [15:0] exp_trunc;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  grant;
    logic        busy;
    logic [15:0] trunc_count;
    int          checkCount;
    int          failCount;
    vec_t        tbl [0:23];
    logic [15:0] satExp [0:3];

    fifo_write_arbiter_if #(.NREQ(4), .dw(8)) bus ();

    fifo_write_arbiter #(
        .NREQ     (4),
        .dw       (8),
        .MAXBURST (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .grant       (grant),
        .busy        (busy),
        .trunc_count (trunc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] last,
                                input logic [31:0] data, input logic full,
                                input logic [3:0] g, input logic [3:0] r, input logic we,
                                input logic [7:0] din, input logic bsy, input logic [15:0] tr);
        vec_t v;
        v.valid = valid; v.last = last; v.data = data; v.full = full;
        v.exp_grant = g; v.exp_ready = r; v.exp_we = we; v.exp_din = din;
        v.exp_busy = bsy; v.exp_trunc = tr;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.req_valid = v.valid;
        bus.req_last  = v.last;
        bus.req_data  = v.data;
        bus.fifo_full = v.full;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkVector(input vec_t v, input string tag);
        checkOutput({tag, " grant"}, 32'(grant), 32'(v.exp_grant));
        checkOutput({tag, " req_ready"}, 32'(bus.req_ready), 32'(v.exp_ready));
        checkOutput({tag, " fifo_we"}, 32'(bus.fifo_we), 32'(v.exp_we));
        checkOutput({tag, " busy"}, 32'(busy), 32'(v.exp_busy));
        checkOutput({tag, " trunc_count"}, 32'(trunc_count), 32'(v.exp_trunc));
        if (v.exp_we) checkOutput({tag, " fifo_din"}, 32'(bus.fifo_din), 32'(v.exp_din));
    endtask

    task automatic runVector(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        applyStimulus(v);
        @(negedge clk);
        checkVector(v, tag);
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst_n      = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;

        // Single source 2: A1,A2,A3, then sources 3 and 0 from rr_ptr=3.
        tbl[0]  = mk(4'b0100, 4'b0000, 32'h00A1_0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h0);
        tbl[1]  = mk(4'b0100, 4'b0000, 32'h00A1_0000, 0, 4'b0100, 4'b0100, 1, 8'hA1, 1, 16'h0);
        tbl[2]  = mk(4'b0100, 4'b0000, 32'h00A2_0000, 0, 4'b0100, 4'b0100, 1, 8'hA2, 1, 16'h0);
        tbl[3]  = mk(4'b0100, 4'b0100, 32'h00A3_0000, 0, 4'b0100, 4'b0100, 1, 8'hA3, 1, 16'h0);
        tbl[4]  = mk(4'b0000, 4'b0000, 32'h0000_0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h0);
        tbl[5]  = mk(4'b1001, 4'b1001, 32'hB100_00C1, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h0);
        tbl[6]  = mk(4'b1001, 4'b1001, 32'hB100_00C1, 0, 4'b1000, 4'b1000, 1, 8'hB1, 1, 16'h0);
        tbl[7]  = mk(4'b0000, 4'b0000, 32'h0000_0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h0);
        // Fairness: all four valid with 2-beat bursts, expected order 0,1,2,3,0.
        tbl[8]  = mk(4'b1111, 4'b0000, 32'h3020_1000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h0);
        tbl[9]  = mk(4'b1111, 4'b0000, 32'h3020_1000, 0, 4'b0001, 4'b0001, 1, 8'h00, 1, 16'h0);
        tbl[10] = mk(4'b1111, 4'b0001, 32'h3020_1001, 0, 4'b0001, 4'b0001, 1, 8'h01, 1, 16'h0);
        tbl[11] = mk(4'b1111, 4'b0000, 32'h3020_1002, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h0);
        tbl[12] = mk(4'b1111, 4'b0000, 32'h3020_1002, 0, 4'b0010, 4'b0010, 1, 8'h10, 1, 16'h0);
        tbl[13] = mk(4'b1111, 4'b0010, 32'h3020_1102, 0, 4'b0010, 4'b0010, 1, 8'h11, 1, 16'h0);
        tbl[14] = mk(4'b1111, 4'b0000, 32'h3020_1202, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h0);
        tbl[15] = mk(4'b1111, 4'b0000, 32'h3020_1202, 0, 4'b0100, 4'b0100, 1, 8'h20, 1, 16'h0);
        tbl[16] = mk(4'b1111, 4'b0100, 32'h3021_1202, 0, 4'b0100, 4'b0100, 1, 8'h21, 1, 16'h0);
        tbl[17] = mk(4'b1111, 4'b0000, 32'h3022_1202, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h0);
        tbl[18] = mk(4'b1111, 4'b0000, 32'h3022_1202, 0, 4'b1000, 4'b1000, 1, 8'h30, 1, 16'h0);
        tbl[19] = mk(4'b1111, 4'b1000, 32'h3122_1202, 0, 4'b1000, 4'b1000, 1, 8'h31, 1, 16'h0);
        tbl[20] = mk(4'b1111, 4'b0000, 32'h3222_1202, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h0);
        tbl[21] = mk(4'b1111, 4'b0000, 32'h3222_1202, 0, 4'b0001, 4'b0001, 1, 8'h02, 1, 16'h0);
        tbl[22] = mk(4'b1111, 4'b0001, 32'h3222_1203, 0, 4'b0001, 4'b0001, 1, 8'h03, 1, 16'h0);
        tbl[23] = mk(4'b0000, 4'b0000, 32'h0000_0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h0);

        satExp[0] = 16'hFFFE;
        satExp[1] = 16'hFFFF;
        satExp[2] = 16'hFFFF;
        satExp[3] = 16'hFFFF;

        repeat (2) @(negedge clk);
        checkOutput("reset grant", 32'(grant), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset fifo_we", 32'(bus.fifo_we), 32'h0);
        checkOutput("reset req_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("reset trunc_count", 32'(trunc_count), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) runVector(tbl[i], $sformatf("vec%0d", i));

        // Truncation: source 0 sends 10 beats; cut after 8, source 1 served, then the tail.
        runVector(mk(4'b0001, 4'b0000, 32'h0000_0040, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h0), "trunc_arb");
        for (int b = 0; b < 8; b++) begin
            runVector(mk(4'b0011, 4'b0010, {16'h0000, 8'h50, 8'(8'h40 + b)}, 0,
                         4'b0001, 4'b0001, 1, 8'(8'h40 + b), 1, 16'h0), $sformatf("trunc_beat%0d", b));
        end
        runVector(mk(4'b0011, 4'b0010, 32'h0000_5048, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h1), "trunc_bubble");
        runVector(mk(4'b0011, 4'b0010, 32'h0000_5048, 0, 4'b0010, 4'b0010, 1, 8'h50, 1, 16'h1), "trunc_src1");
        runVector(mk(4'b0001, 4'b0000, 32'h0000_0048, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h1), "trunc_bubble2");
        runVector(mk(4'b0001, 4'b0000, 32'h0000_0048, 0, 4'b0001, 4'b0001, 1, 8'h48, 1, 16'h1), "trunc_tail9");
        runVector(mk(4'b0001, 4'b0001, 32'h0000_0049, 0, 4'b0001, 4'b0001, 1, 8'h49, 1, 16'h1), "trunc_tail10");
        runVector(mk(4'b0000, 4'b0000, 32'h0000_0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h1), "trunc_done");

        // Full stall: source 1 sends 8 beats with last on the 8th, FIFO full for 5 cycles after beat 2.
        runVector(mk(4'b0010, 4'b0000, 32'h0000_6000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h1), "stall_arb");
        for (int b = 0; b < 2; b++) begin
            runVector(mk(4'b0010, 4'b0000, {16'h0000, 8'(8'h60 + b), 8'h00}, 0,
                         4'b0010, 4'b0010, 1, 8'(8'h60 + b), 1, 16'h1), $sformatf("stall_beat%0d", b));
        end
        for (int s = 0; s < 5; s++) begin
            runVector(mk(4'b0010, 4'b0000, 32'h0000_6200, 1, 4'b0010, 4'b0000, 0, 8'h00, 1, 16'h1),
                      $sformatf("stall_full%0d", s));
        end
        for (int b = 2; b < 8; b++) begin
            runVector(mk(4'b0010, (b == 7) ? 4'b0010 : 4'b0000, {16'h0000, 8'(8'h60 + b), 8'h00}, 0,
                         4'b0010, 4'b0010, 1, 8'(8'h60 + b), 1, 16'h1), $sformatf("stall_beat%0d", b));
        end
        runVector(mk(4'b0000, 4'b0000, 32'h0000_0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h1), "stall_done");

        // Reset mid-burst at beat 3 of source 3, asserted between clock edges.
        runVector(mk(4'b1000, 4'b0000, 32'h7000_0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h1), "rst_arb");
        runVector(mk(4'b1000, 4'b0000, 32'h7000_0000, 0, 4'b1000, 4'b1000, 1, 8'h70, 1, 16'h1), "rst_beat1");
        runVector(mk(4'b1000, 4'b0000, 32'h7100_0000, 0, 4'b1000, 4'b1000, 1, 8'h71, 1, 16'h1), "rst_beat2");
        runVector(mk(4'b1000, 4'b0000, 32'h7200_0000, 0, 4'b1000, 4'b1000, 1, 8'h72, 1, 16'h1), "rst_beat3");
        #1;
        rst_n = 1'b0;
        applyStimulus(mk(4'b1010, 4'b0010, 32'h7300_8100, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h0));
        #1;
        checkOutput("async_rst grant", 32'(grant), 32'h0);
        checkOutput("async_rst busy", 32'(busy), 32'h0);
        checkOutput("async_rst fifo_we", 32'(bus.fifo_we), 32'h0);
        checkOutput("async_rst req_ready", 32'(bus.req_ready), 32'h0);
        checkOutput("async_rst trunc_count", 32'(trunc_count), 32'h0);
        #1;
        rst_n = 1'b1;
        runVector(mk(4'b1010, 4'b0010, 32'h7300_8100, 0, 4'b0010, 4'b0010, 1, 8'h81, 1, 16'h0), "rst_regrant");
        runVector(mk(4'b0000, 4'b0000, 32'h0000_0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'h0), "rst_done");

        // Saturation: preload the counter near the top, then truncate source 2 three times.
        force dut.trunc_q = 16'hFFFE;
        #1;
        release dut.trunc_q;
        #1;
        checkOutput("sat preload", 32'(trunc_count), 32'h0000_FFFE);
        for (int k = 0; k < 3; k++) begin
            runVector(mk(4'b0100, 4'b0000, 32'h0090_0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, satExp[k]),
                      $sformatf("sat_bubble%0d", k));
            for (int b = 0; b < 8; b++) begin
                runVector(mk(4'b0100, 4'b0000, 32'h0090_0000, 0, 4'b0100, 4'b0100, 1, 8'h90, 1, satExp[k]),
                          $sformatf("sat_burst%0d_beat%0d", k, b));
            end
        end
        runVector(mk(4'b0000, 4'b0000, 32'h0000_0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, satExp[3]), "sat_final");
        runVector(mk(4'b0000, 4'b0000, 32'h0000_0000, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, satExp[3]), "sat_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
